phase_sweep_sel: RTL and testbench
==================================

# phase_sweep_sel

Automatic sampling-phase selector for the 4x-oversampled link. It sits between the transmitter's 12-bit filter output and the receiver's phase input. Over a fixed window of symbols it accumulates per-phase sample magnitude and drives the receiver's 2-bit phase select with the phase of maximum energy. It replaces the static phase constant in the full-chain bench and on the board.

## Interface
Parameters:
- WIN_LOG2, 4: window length is 2^WIN_LOG2 symbols, with 4 samples per symbol.
- PHASE_INIT, 2: value of o_phase after reset.

Ports:
- clk  in  1  system clock (CLK100MHZ at top level).
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  block enable; shares the rx enable.
- i_valid  in  1  symbol strobe from the fsm; marks the phase-0 sample.
- i_sample  in  12  signed two's-complement tx filter output, one sample per clock.
- o_phase  out  2  selected phase, fed to the rx phase input.
- o_update  out  1  one-cycle pulse when a window decision is registered.
- o_locked  out  1  high when the same phase has won two consecutive windows.

## Operation
- Phase counter pcnt[1:0]:
  - Increments every clock while i_enable=1.
  - In a cycle with i_valid=1, the current sample is phase 0 and pcnt loads 1 for the next cycle.
  - pcnt wraps 3->0.
- Magnitude:
  - mag = |i_sample|, 11 bits unsigned.
  - -2048 saturates to 2047.
- Accumulators acc[0..3]:
  - Width 11+WIN_LOG2 bits, unsigned.
  - Cannot overflow: maximum value is 2047·2^WIN_LOG2.
- Symbol counter scnt: WIN_LOG2 bits; increments on each phase-3 sample accumulated in ACQ.
- FSM states IDLE, ALIGN, ACQ, DECIDE:
  - IDLE: accumulators and scnt cleared. Move to ALIGN when i_enable=1.
  - ALIGN: wait for i_valid=1. That same sample is accumulated as phase 0 and the state moves to ACQ.
  - ACQ: acc[pcnt] += mag every cycle. After the phase-3 sample with scnt = 2^WIN_LOG2-1, move to DECIDE.
  - DECIDE (one cycle):
    - Argmax over acc; ties go to the lowest index.
    - Register o_phase and pulse o_update.
    - Clear acc and scnt, then go to ALIGN.
    - The sample presented in this cycle is discarded.
- o_locked:
  - Set at a decision whose winner equals the previous winner.
  - Cleared at a decision whose winner differs.
  - The first decision after IDLE never sets o_locked.
- i_enable=0 in any state:
  - Next state is IDLE; acc and scnt are cleared.
  - o_locked is cleared and the previous-winner history is invalidated.
  - o_phase holds its value.
- i_valid arriving mid-symbol in ACQ: pcnt realigns to phase 0 for that sample. The accumulation proceeds and no error is flagged.

## Timing
- Reset values: o_phase=PHASE_INIT, o_update=0, o_locked=0, state=IDLE, pcnt=0, acc=0, scnt=0.
- Decision latency: if the last window sample is accumulated at edge E, then o_phase, o_update and o_locked change at edge E+1. o_update is high for exactly one cycle.
- Window period in steady state with periodic i_valid:
  - 4·2^WIN_LOG2 accumulated samples.
  - 1 DECIDE cycle.
  - ALIGN wait of up to 4 cycles, which is 3 cycles when i_valid is every 4th clock.
- Reset asserted mid-window: all registers take reset values asynchronously and no o_update is produced.

## Configuration
- Macro PHASE_SWEEP_HYST_EN.
- Defined:
  - In DECIDE, o_phase changes only if acc[winner] > acc[o_phase] + (acc[o_phase] >> 3). Otherwise o_phase holds.
  - o_update still pulses every decision.
  - o_locked compares the resulting o_phase values.
- Undefined: o_phase always takes the argmax winner.

## Test plan
- Impulse on phase 2:
  - Stimulus: WIN_LOG2=4, i_valid every 4th clock, i_sample=100 on phase 2 and 0 elsewhere.
  - Response: first o_update gives o_phase=2 with acc[2]=1600; o_locked=1 at the second o_update.
- Saturation and tie:
  - Stimulus: all samples -2048 for one window.
  - Response: every acc equals 32752, o_phase=0 (lowest index wins), no wrap.
- Phase change:
  - Stimulus: window 1 energy on phase 1 (amplitude 50), window 2 on phase 3 (amplitude 50).
  - Response: o_phase goes 1 then 3; o_locked stays 0 after window 2.
- Disable mid-window:
  - Stimulus: drop i_enable after 20 samples, re-enable 10 cycles later.
  - Response: no o_update, o_phase unchanged, o_locked=0, next decision exactly one full window after re-alignment.
- Async reset mid-ACQ:
  - Stimulus: pull rst low between clock edges.
  - Response: o_phase=PHASE_INIT immediately, o_update=0.
- Hysteresis (PHASE_SWEEP_HYST_EN):
  - Stimulus: current phase 2 with acc=1000, then a challenger on phase 0 with acc=1100.
  - Response: o_phase stays 2.
  - Stimulus: same, with challenger acc=1200.
  - Response: o_phase becomes 0.

Source files
------------

// File: rtl/phase_sweep_sel.sv
// -----------------------------------------------------------------------------
// phase_sweep_sel
//   Automatic sampling-phase selector for the 4x-oversampled link. Over a
//   window of 2^WIN_LOG2 symbols (4 samples each) it accumulates the sample
//   magnitude per phase and selects the phase with the most energy for the
//   receiver.
//
//   Optional feature macro: PHASE_SWEEP_HYST_EN
//     When defined, the selected phase only moves to a new winner whose
//     energy exceeds the current phase's energy by more than 1/8.
//
// Parameters
//   WIN_LOG2   : log2 of the window length in symbols
//   PHASE_INIT : phase presented after reset
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   i_enable in   block enable (shared with the rx enable)
//   i_valid  in   symbol strobe, marks the phase-0 sample
//   i_sample in   12-bit signed tx filter output, one sample per clock
//   o_phase  out  selected sampling phase
//   o_update out  one-cycle pulse per window decision
//   o_locked out  same phase has won two consecutive decisions
// -----------------------------------------------------------------------------
module phase_sweep_sel #(
    parameter int WIN_LOG2   = 4,
    parameter int PHASE_INIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_valid,
    input  logic [11:0] i_sample,
    output logic [1:0]  o_phase,
    output logic        o_update,
    output logic        o_locked
);

    localparam int AW  = 11 + WIN_LOG2;
    localparam int AW1 = AW + 1;
    localparam logic [WIN_LOG2-1:0] SCNT_LAST = {WIN_LOG2{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACQ    = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // Absolute value of a 12-bit two's-complement sample; -2048 has no
    // 11-bit magnitude and is clamped to 2047.
    function automatic logic [10:0] sat_mag(input logic [11:0] s);
        logic [11:0] neg;
        neg = 12'd0 - s;
        if (s == 12'h800) begin
            sat_mag = 11'h7ff;
        end else if (s[11]) begin
            sat_mag = neg[10:0];
        end else begin
            sat_mag = s[10:0];
        end
    endfunction

    state_t                 state_r;
    logic [1:0]             pcnt_r;
    logic [WIN_LOG2-1:0]    scnt_r;
    logic [AW-1:0]          acc_r [4];
    logic [1:0]             phase_r;
    logic                   update_r;
    logic                   locked_r;
    logic [1:0]             hist_r;
    logic                   hist_valid_r;

    logic [10:0]            mag_s;
    logic [1:0]             ph_s;
    logic [1:0]             win_s;
    logic [AW-1:0]          best_s;
    logic                   gt_s;
    logic [1:0]             new_phase_s;

    assign o_phase  = phase_r;
    assign o_update = update_r;
    assign o_locked = locked_r;

    // A strobe always forces the current sample to phase 0.
    assign mag_s = sat_mag(i_sample);
    assign ph_s  = i_valid ? 2'd0 : pcnt_r;

    // Argmax over the accumulators; strict compare keeps the lowest index on ties.
    always_comb begin
        win_s  = 2'd0;
        best_s = acc_r[0];
        gt_s   = 1'b0;
        for (int i = 1; i < 4; i++) begin
            gt_s   = (acc_r[i] > best_s);
            win_s  = gt_s ? 2'(i) : win_s;
            best_s = gt_s ? acc_r[i] : best_s;
        end
    end

`ifdef PHASE_SWEEP_HYST_EN
    logic [AW-1:0]  cur_acc_s;
    logic [AW1-1:0] thr_s;

    // Hysteresis: the challenger must beat the current phase by more than 1/8.
    always_comb begin
        cur_acc_s = acc_r[phase_r];
        thr_s     = AW1'(cur_acc_s) + AW1'(cur_acc_s >> 3'd3);
        if (AW1'(acc_r[win_s]) > thr_s) begin
            new_phase_s = win_s;
        end else begin
            new_phase_s = phase_r;
        end
    end
`else
    assign new_phase_s = win_s;
`endif

    // Phase counter: free-running modulo 4, realigned by every strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r <= 2'd0;
        end else if (!i_enable) begin
            pcnt_r <= 2'd0;
        end else if (i_valid) begin
            pcnt_r <= 2'd1;
        end else begin
            pcnt_r <= pcnt_r + 2'd1;
        end
    end

    // Window FSM with accumulators, decision and lock tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            scnt_r       <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_r[i] <= '0;
            end
            phase_r      <= 2'(PHASE_INIT);
            update_r     <= 1'b0;
            locked_r     <= 1'b0;
            hist_r       <= 2'd0;
            hist_valid_r <= 1'b0;
        end else begin
            update_r <= 1'b0;
            if (!i_enable) begin
                // Disabling abandons the window and forgets the winner history;
                // the selected phase is kept for the receiver.
                state_r      <= ST_IDLE;
                scnt_r       <= '0;
                for (int i = 0; i < 4; i++) begin
                    acc_r[i] <= '0;
                end
                locked_r     <= 1'b0;
                hist_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        scnt_r  <= '0;
                        for (int i = 0; i < 4; i++) begin
                            acc_r[i] <= '0;
                        end
                        state_r <= ST_ALIGN;
                    end
                    ST_ALIGN: begin
                        if (i_valid) begin
                            acc_r[0] <= acc_r[0] + AW'(mag_s);
                            state_r  <= ST_ACQ;
                        end else begin
                            state_r  <= ST_ALIGN;
                        end
                    end
                    ST_ACQ: begin
                        acc_r[ph_s] <= acc_r[ph_s] + AW'(mag_s);
                        if (ph_s == 2'd3) begin
                            if (scnt_r == SCNT_LAST) begin
                                state_r <= ST_DECIDE;
                            end else begin
                                scnt_r  <= scnt_r + WIN_LOG2'(1'b1);
                            end
                        end else begin
                            state_r <= ST_ACQ;
                        end
                    end
                    ST_DECIDE: begin
                        // Sample presented this cycle is not accumulated.
                        phase_r      <= new_phase_s;
                        update_r     <= 1'b1;
                        locked_r     <= hist_valid_r && (new_phase_s == hist_r);
                        hist_r       <= new_phase_s;
                        hist_valid_r <= 1'b1;
                        scnt_r       <= '0;
                        for (int i = 0; i < 4; i++) begin
                            acc_r[i] <= '0;
                        end
                        state_r      <= ST_ALIGN;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sweep_sel.sv
// -----------------------------------------------------------------------------
// tb_phase_sweep_sel
//   Self-checking bench for phase_sweep_sel. A behavioural model tracks the
//   window as sums per phase (phase = clocks since the last strobe, mod 4) and
//   computes each decision by argmax; every negative clock edge the DUT outputs
//   are compared to it. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_phase_sweep_sel;

    localparam int WL    = 4;
    localparam int NSYM  = 1 << WL;
    localparam int PINIT = 2;
    localparam int NCAP  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        vld = 1'b0;
    logic [11:0] smp = 12'd0;
    logic [1:0]  phase;
    logic        upd;
    logic        locked;

    phase_sweep_sel #(.WIN_LOG2(WL), .PHASE_INIT(PINIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (en),
        .i_valid  (vld),
        .i_sample (smp),
        .o_phase  (phase),
        .o_update (upd),
        .o_locked (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // model state
    int m_phase, m_upd, m_locked, m_hist, m_histv;
    int m_armed, m_inwin, m_pend, m_since, m_p3;
    int m_sum [4];
    int m_snap [4];

    // captured decisions
    int ncap = 0;
    int nupd = 0;
    int cap_phase [NCAP];
    int cap_lock  [NCAP];
    int cap_cyc   [NCAP];
    int cap_snap  [NCAP][4];

    function automatic int magf(input logic [11:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    // behavioural model, evaluated on the same edges as the DUT
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = PINIT; m_upd = 0; m_locked = 0; m_hist = 0; m_histv = 0;
                m_armed = 0; m_inwin = 0; m_pend = 0; m_since = 0; m_p3 = 0;
                for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_snap[k] = 0; end
            end else begin
                m_upd = 0;
                if (!en) begin
                    m_armed = 0; m_inwin = 0; m_pend = 0; m_p3 = 0;
                    m_locked = 0; m_histv = 0;
                    for (int k = 0; k < 4; k++) m_sum[k] = 0;
                end else if (m_pend != 0) begin
                    int w, np;
                    w = 0;
                    for (int k = 1; k < 4; k++) if (m_sum[k] > m_sum[w]) w = k;
                    np = w;
`ifdef PHASE_SWEEP_HYST_EN
                    if (!(m_sum[w] > m_sum[m_phase] + m_sum[m_phase] / 8)) np = m_phase;
`endif
                    m_locked = (m_histv != 0 && np == m_hist) ? 1 : 0;
                    m_hist = np; m_histv = 1; m_phase = np; m_upd = 1;
                    for (int k = 0; k < 4; k++) begin m_snap[k] = m_sum[k]; m_sum[k] = 0; end
                    m_p3 = 0; m_pend = 0; m_inwin = 0;
                end else if (m_armed == 0) begin
                    m_armed = 1;
                end else if (m_inwin == 0) begin
                    if (vld) begin
                        m_inwin = 1; m_since = 0;
                        m_sum[0] += magf(smp);
                    end
                end else begin
                    int ph;
                    m_since = vld ? 0 : m_since + 1;
                    ph = m_since % 4;
                    m_sum[ph] += magf(smp);
                    if (ph == 3) begin
                        m_p3++;
                        if (m_p3 == NSYM) m_pend = 1;
                    end
                end
            end
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (int'(phase) != m_phase) begin
                errors++;
                $display("FAIL phase cyc=%0d: got %0d want %0d", cyc, phase, m_phase);
            end
            checks++;
            if (int'(upd) != m_upd) begin
                errors++;
                $display("FAIL update cyc=%0d: got %0d want %0d", cyc, upd, m_upd);
            end
            checks++;
            if (int'(locked) != m_locked) begin
                errors++;
                $display("FAIL locked cyc=%0d: got %0d want %0d", cyc, locked, m_locked);
            end
            if (upd === 1'b1) begin
                nupd++;
                if (ncap < NCAP) begin
                    cap_phase[ncap] = phase;
                    cap_lock[ncap]  = locked;
                    cap_cyc[ncap]   = cyc;
                    for (int k = 0; k < 4; k++) cap_snap[ncap][k] = m_snap[k];
                    ncap++;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [11:0] s);
        @(negedge clk);
        en = e; vld = v; smp = s;
        if (v) vld_edge = cyc + 1;
    endtask

    // n symbols, strobe every 4th clock, constant amplitude per phase
    task automatic syms(input int n, input int a0, input int a1, input int a2, input int a3);
        int amp;
        for (int s = 0; s < n; s++) begin
            for (int p = 0; p < 4; p++) begin
                amp = (p == 0) ? a0 : (p == 1) ? a1 : (p == 2) ? a2 : a3;
                step(1'b1, (p == 0), 12'(amp));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; vld = 1'b0; smp = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int b, a_edge, n0, pos;

    initial begin
        do_reset();
        chk("reset_phase", phase, PINIT);
        chk("reset_update", upd, 0);
        chk("reset_locked", locked, 0);

        // impulse of 100 on phase 2
        b = ncap;
        syms(1 + 2 * (NSYM + 1) + 2, 0, 0, 100, 0);
        chk("imp_count", ncap - b, 2);
        chk("imp_phase", cap_phase[b], 2);
        chk("imp_acc2", cap_snap[b][2], 1600);
        chk("imp_acc0", cap_snap[b][0], 0);
        chk("imp_lock1", cap_lock[b], 0);
        chk("imp_lock2", cap_lock[b + 1], 1);

        // saturation and four-way tie
        do_reset();
        b = ncap;
        syms(NSYM + 3, -2048, -2048, -2048, -2048);
        chk("sat_count", ncap - b, 1);
        chk("sat_phase", cap_phase[b], 0);
        for (int k = 0; k < 4; k++) chk("sat_acc", cap_snap[b][k], 32752);
        chk("sat_lock", cap_lock[b], 0);

        // phase change 1 -> 3
        do_reset();
        b = ncap;
        syms(NSYM + 2, 0, 50, 0, 0);
        syms(NSYM + 2, 0, 0, 0, 50);
        chk("chg_count", ncap - b, 2);
        chk("chg_phase1", cap_phase[b], 1);
        chk("chg_phase2", cap_phase[b + 1], 3);
        chk("chg_lock2", cap_lock[b + 1], 0);

        // disable mid-window, then re-enable
        do_reset();
        b = ncap;
        syms(1 + 2 * (NSYM + 1), 0, 50, 0, 0);
        chk("dis_pre_locked", locked, 1);
        syms(5, 0, 50, 0, 0);
        repeat (10) step(1'b0, 1'b0, 12'd0);
        chk("dis_count", ncap - b, 2);
        chk("dis_phase", phase, 1);
        chk("dis_locked", locked, 0);
        syms(1, 0, 0, 0, 40);
        syms(1, 0, 0, 0, 40);
        a_edge = vld_edge;
        syms(NSYM + 1, 0, 0, 0, 40);
        chk("dis_count2", ncap - b, 3);
        chk("dis_latency", cap_cyc[b + 2] - a_edge, 4 * NSYM);
        chk("dis_phase2", cap_phase[b + 2], 3);
        chk("dis_lock3", cap_lock[b + 2], 0);

        // async reset in the middle of a window
        do_reset();
        syms(NSYM + 4, 0, 50, 0, 0);
        chk("ar_pre_phase", phase, 1);
        n0 = nupd;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_phase", phase, PINIT);
        chk("ar_update", upd, 0);
        chk("ar_locked", locked, 0);
        en = 1'b0; vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_no_update", nupd - n0, 0);

`ifdef PHASE_SWEEP_HYST_EN
        // hysteresis: challenger 1100 vs 1000 holds, 1200 vs 1000 moves
        do_reset();
        b = ncap;
        syms(1, 0, 0, 0, 0);
        syms(1, 80, 0, 70, 0);
        syms(NSYM - 1, 68, 0, 62, 0);
        syms(1, 0, 0, 0, 0);
        syms(1, 75, 0, 70, 0);
        syms(NSYM - 1, 75, 0, 62, 0);
        syms(2, 0, 0, 0, 0);
        chk("hys_count", ncap - b, 2);
        chk("hys_acc2", cap_snap[b][2], 1000);
        chk("hys_acc0", cap_snap[b][0], 1100);
        chk("hys_hold", cap_phase[b], 2);
        chk("hys_move", cap_phase[b + 1], 0);
`endif

        // randomized traffic with strobe jitter and enable drops
        do_reset();
        n0 = nupd;
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic [11:0] s;
            if ($urandom_range(0, 399) == 0) begin
                int d;
                d = $urandom_range(1, 12);
                for (int j = 0; j < d; j++) step(1'b0, 1'b0, 12'($urandom));
                pos = 0;
            end
            v = ((pos % 4) == 0) || ($urandom_range(0, 59) == 0);
            if (v) pos = 0;
            if ($urandom_range(0, 3) == 0) s = 12'($urandom);
            else if ((pos % 4) == 1) s = 12'($urandom_range(0, 1500));
            else s = 12'($urandom_range(0, 300));
            step(1'b1, v, s);
            pos++;
        end
        checks++;
        if (nupd - n0 < 5) begin
            errors++;
            $display("FAIL rand_decisions: got %0d want at least 5", nupd - n0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
